// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, helpers and types for the multi-port register file.
//   DW_DEF/NREG_DEF/NRD_DEF/NWR_DEF : default parameter values
//   DW_MAX/AW_MAX                   : widest data/address a write bundle can carry
//   clog2_min1()                    : address width, never below 1
//   wr_bundle_t                     : one write port (en, addr, data), zero-extended
package regfile_pkg;

    localparam int DW_DEF   = 16;
    localparam int NREG_DEF = 16;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;

    // Write bundles are sized for the largest supported configuration so the
    // type can live here; narrower instances zero-extend into it.
    localparam int DW_MAX = 64;
    localparam int AW_MAX = 8;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic              en;
        logic [AW_MAX-1:0] addr;
        logic [DW_MAX-1:0] data;
    } wr_bundle_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus of the register file.
//   rd_addr/rd_data/rd_busy : NRD combinational read ports (packed, port p at p*W)
//   wr_en/wr_addr/wr_data   : NWR write ports
//   rsv_en/rsv_addr         : reservation (busy-set) request
//   busy_vec                : registered busy bits
// master = decode/writeback side, slave = register file.
interface regfile_mp_if #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = regfile_pkg::clog2_min1(NREG);

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port.
//   addr     : register to read
//   regs     : stored register array
//   wr       : write bundles (already stripped of register-0 writes when
//              register 0 is hard-wired)
//   busy     : registered busy bits
//   in_reset : forces outputs to zero while reset is held
//   data     : stored value, or bypassed value of the highest-numbered writer
//   busy_out : busy bit, cleared when a write to addr is in flight this cycle
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DW       = 16,
    parameter int NREG     = 16,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = 4
) (
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   regs [NREG],
    input  wr_bundle_t      wr   [NWR],
    input  logic [NREG-1:0] busy,
    input  logic            in_reset,
    output logic [DW-1:0]   data,
    output logic            busy_out
);
    logic hit;

    always_comb begin
        data = regs[addr];
        hit  = 1'b0;
        // Ascending scan: a later port overrides an earlier one, so the
        // youngest writer is the one forwarded.
        for (int w = 0; w < NWR; w++) begin
            if (wr[w].en && (wr[w].addr == AW_MAX'(addr))) begin
                data = wr[w].data[DW-1:0];
                hit  = 1'b1;
            end
        end
        busy_out = busy[addr] & ~hit;
        if (in_reset || ((ZERO_REG != 0) && (addr == '0))) begin
            data     = '0;
            busy_out = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parameterised multi-port register file with busy scoreboard.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-low reset
//   bus : regfile_mp_if slave (read ports, write ports, reservation, busy_vec)
// Storage and busy bits are flops; reads are combinational with write bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int NWR      = NWR_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = clog2_min1(NREG);

    logic [DW-1:0]   regs_reg  [NREG];
    logic [DW-1:0]   regs_next [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    wr_bundle_t      wr_bus    [NWR];
    logic            rsv_eff;

    // Writes to a hard-wired register 0 are dropped here, so neither storage,
    // busy clear nor bypass ever sees them.
    for (genvar gi = 0; gi < NWR; gi++) begin : g_wr
        logic [AW-1:0] a;
        assign a = bus.wr_addr[gi*AW +: AW];
        assign wr_bus[gi] = '{
            en:   bus.wr_en[gi] & ~((ZERO_REG != 0) && (a == '0)),
            addr: AW_MAX'(a),
            data: DW_MAX'(bus.wr_data[gi*DW +: DW])
        };
    end

    assign rsv_eff = bus.rsv_en & ~((ZERO_REG != 0) && (bus.rsv_addr == '0));

    always_comb begin
        regs_next = regs_reg;
        busy_next = busy_reg;
        // Ascending port order gives the last port the final word on conflicts.
        for (int w = 0; w < NWR; w++) begin
            if (wr_bus[w].en) begin
                regs_next[wr_bus[w].addr[AW-1:0]] = wr_bus[w].data[DW-1:0];
                busy_next[wr_bus[w].addr[AW-1:0]] = 1'b0;
            end
        end
        // Applied after the clears: a new producer supersedes the retiring one.
        if (rsv_eff) begin
            busy_next[bus.rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_reg <= '{default: '0};
            busy_reg <= '0;
        end else begin
            regs_reg <= regs_next;
            busy_reg <= busy_next;
        end
    end

    assign bus.busy_vec = busy_reg;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        regfile_rdport #(
            .DW       (DW),
            .NREG     (NREG),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_rdport (
            .addr     (bus.rd_addr[gi*AW +: AW]),
            .regs     (regs_reg),
            .wr       (wr_bus),
            .busy     (busy_reg),
            .in_reset (!rst),
            .data     (bus.rd_data[gi*DW +: DW]),
            .busy_out (bus.rd_busy[gi])
        );
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined core. It replaces the fixed 16×16, 2-read/1-write file with configurable data width, depth, read-port count and write-port count. It adds per-register busy (scoreboard) bits so decode can detect pending producers. It sits between decode (reads, reservations) and writeback (writes), and keeps same-cycle write-before-read bypassing.

## Interface
Parameters:
- DW, 16, data width in bits
- NREG, 16, number of registers (power of two, ≥2); AW = $clog2(NREG) is derived
- NRD, 2, number of read ports (1–4)
- NWR, 2, number of write ports (1–2)
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- rd_addr  in  NRD*AW  read addresses; port p occupies bits [p*AW +: AW]
- rd_data  out  NRD*DW  read data with bypass, combinational
- rd_busy  out  NRD  busy status of each addressed register, with bypass
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*DW  write data
- rsv_en  in  1  reserve a register: set its busy bit
- rsv_addr  in  AW  register to reserve
- busy_vec  out  NREG  registered busy bits, bit r = register r

## Operation
- Storage: NREG×DW flops. Busy: NREG flops.
- Write: on clk, for each port w with wr_en[w], reg[wr_addr[w]] ← wr_data[w].
  - If both ports target the same register, port NWR-1 wins (it carries the younger instruction).
- Busy update per register r, evaluated each clock edge:
  - Clear when any enabled write targets r.
  - Set when rsv_en and rsv_addr==r.
  - Set has priority over clear, because the new producer supersedes the retiring one.
- Read port p, combinational:
  - If any enabled write targets rd_addr[p], rd_data = data of the winning writer (bypass).
  - Otherwise rd_data = stored value.
- rd_busy[p] = busy[rd_addr[p]] & ~(any enabled write to rd_addr[p]).
  - A reservation in the current cycle is not visible until the next cycle, so an instruction reading its own destination never stalls on itself.
- ZERO_REG=1:
  - Reads of address 0 return 0 and rd_busy=0, regardless of writes or bypass.
  - Writes and reservations to register 0 are dropped; busy_vec[0] stays 0.
- ZERO_REG=0: register 0 behaves like any other register.
- While rst is low, all rd_data = 0 and all rd_busy = 0 (forced combinationally).

## Timing
- Reset: asserting rst immediately clears every register and busy bit. Outputs during and after reset: rd_data = 0, rd_busy = 0, busy_vec = 0.
- Reset mid-operation: any write or reservation in the same cycle is lost. The first edge after rst deasserts is a normal update edge.
- Read latency 0 (combinational from rd_addr / wr_* to rd_data / rd_busy). Write-to-storage latency 1 edge.
- busy_vec updates 1 edge after rsv_en or write; it has no bypass.
- Simultaneous reserve and write to the same register: busy = 1 after the edge, data = written value.
- Simultaneous writes to the same register from both ports: the stored value and the bypassed value both come from port NWR-1.
- No handshake. Writers and the reserver are always accepted in the cycle they assert.

## Structure
- Package regfile_pkg holds:
  - default parameter constants DW_DEF, NREG_DEF, NRD_DEF, NWR_DEF
  - function clog2_min1, which returns ≥1 for AW
  - a packed type for the write-port bundle (en, addr, data)
- Sub-module regfile_rdport, instantiated NRD times in a generate loop. Given the address, the stored array view, the write bundles and the busy vector, it produces rd_data and rd_busy, including the priority bypass and zero-register masking.
- Top level holds the storage, the write decode with last-port priority, and the busy set/clear logic.

## Test plan
- Reset: write R5=0x1234, assert rst low mid-cycle → rd_data=0 and busy_vec=0 immediately; R5 reads 0 after release.
- Bypass: wr_en[0], wr_addr=3, wr_data=0xBEEF, rd_addr[0]=3 in the same cycle → rd_data[0]=0xBEEF before the edge; still 0xBEEF after the edge with the write removed.
- Dual-write conflict: port0 writes R7=0x1111, port1 writes R7=0x2222 → bypass shows 0x2222 and stored value is 0x2222.
- Scoreboard: rsv R9 → busy_vec[9]=1 next cycle, rd_busy=1. Write R9 → rd_busy=0 in that cycle, busy_vec[9]=0 after the edge. Reserve and write R9 in the same cycle → busy_vec[9]=1.
- Zero register (ZERO_REG=1): write R0=0xFFFF and rsv R0 → rd_data=0, rd_busy=0, busy_vec[0]=0. With ZERO_REG=0, R0 holds 0xFFFF.
- Parameter sweep DW=32, NREG=32, NRD=3, NWR=1 → random writes and reads match a reference model over 10k cycles.
